// File: rtl/rtc_pkg.sv
// Shared constants and channel state type for the RTC / multi-pulse block.
package rtc_pkg;

    localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;
    localparam logic [29:0] NS_MAX     = 30'd999_999_999;
    localparam int          RTC_W      = 80;
    localparam int          NS_W       = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SEC = 2'd1,
        RUN      = 2'd2
    } ch_state_t;

endpackage

// File: rtl/rtc_pulse_ch.sv
// One programmable pulse channel: fires on each second boundary and then on
// every period edge inside the second, holding the output for a width count.
module rtc_pulse_ch
    import rtc_pkg::*;
#(
    parameter int PW_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [NS_W-1:0]   i_period,
    input  logic [PW_W-1:0]   i_width,
    input  logic [NS_W-1:0]   i_ns_n,
    input  logic              i_rollover,
    input  logic              i_discont,
    output logic              o_pulse
);

    ch_state_t         r_state, w_state_n;
    logic [NS_W-1:0]   r_next_edge, w_next_edge_n;
    logic [PW_W-1:0]   r_cnt, w_cnt_n;
    logic              r_pulse, w_pulse_n;
    logic [NS_W-1:0]   w_eff_period;
    logic [PW_W-1:0]   w_eff_width;
    logic [NS_W:0]     w_edge_sum;
    logic              w_fire;

    // Period 0 or out of range means once per second; 1e9 acts as a
    // sentinel edge that ns never reaches, leaving only the rollover fire.
    function automatic logic [NS_W-1:0] eff_period(input logic [NS_W-1:0] p);
        return ((p == '0) || (p >= NS_PER_SEC)) ? NS_PER_SEC : p;
    endfunction

    // Next-state, next edge and width-counter logic
    always_comb begin
        w_state_n     = r_state;
        w_next_edge_n = r_next_edge;
        w_fire        = 1'b0;
        w_eff_period  = eff_period(i_period);
        w_eff_width   = (i_width == '0) ? PW_W'(1) : i_width;
        w_edge_sum    = {1'b0, r_next_edge} + {1'b0, w_eff_period};

        if (!i_en) begin
            w_state_n = IDLE;
        end else if (i_discont) begin
            w_state_n = WAIT_SEC;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n = WAIT_SEC;
                end
                WAIT_SEC: begin
                    if (i_rollover) begin
                        w_fire        = 1'b1;
                        w_state_n     = RUN;
                        w_next_edge_n = w_eff_period;
                    end
                end
                RUN: begin
                    if (i_rollover) begin
                        w_fire        = 1'b1;
                        w_next_edge_n = w_eff_period;
                    end else if (i_ns_n >= r_next_edge) begin
                        w_fire        = 1'b1;
                        w_next_edge_n = (w_edge_sum >= {1'b0, NS_PER_SEC}) ?
                                        NS_PER_SEC : w_edge_sum[NS_W-1:0];
                    end
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end

        // A fire while high reloads the count so the pulse stays continuous;
        // a time discontinuity drops any pulse in progress.
        if (!i_en || i_discont) begin
            w_pulse_n = 1'b0;
            w_cnt_n   = '0;
        end else if (w_fire) begin
            w_pulse_n = 1'b1;
            w_cnt_n   = w_eff_width - PW_W'(1);
        end else if (r_cnt != '0) begin
            w_pulse_n = 1'b1;
            w_cnt_n   = r_cnt - PW_W'(1);
        end else begin
            w_pulse_n = 1'b0;
            w_cnt_n   = '0;
        end
    end

    // State, edge, counter and pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_next_edge <= '0;
            r_cnt       <= '0;
            r_pulse     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_next_edge <= w_next_edge_n;
            r_cnt       <= w_cnt_n;
            r_pulse     <= w_pulse_n;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/rtc_multi_pulse.sv
// PTP real-time counter (seconds / ns / fractional ns) with clear, offset
// load and signed step adjust, plus N_CH second-aligned pulse channels.
module rtc_multi_pulse
    import rtc_pkg::*;
#(
    parameter int FRAC_W = 26,
    parameter int SEC_W  = 48,
    parameter int N_CH   = 2,
    parameter int PW_W   = 16
) (
    input  logic                      rtc_clk,
    input  logic                      rtc_rst,
    input  logic [31:0]               tick_inc_i,
    input  logic                      clr_i,
    input  logic                      ofst_ld_i,
    input  logic [SEC_W-1:0]          sc_ofst_i,
    input  logic [NS_W-1:0]           ns_ofst_i,
    input  logic                      adj_i,
    input  logic                      adj_neg_i,
    input  logic [NS_W-1:0]           adj_ns_i,
    input  logic [N_CH-1:0]           ch_en_i,
    input  logic [N_CH*NS_W-1:0]      ch_period_i,
    input  logic [N_CH*PW_W-1:0]      ch_width_i,
    output logic [SEC_W+2+NS_W-1:0]   rtc_std_o,
    output logic                      sec_pulse_o,
    output logic [N_CH-1:0]           pulse_o
);

    logic [SEC_W-1:0]     r_sec, w_sec_n;
    logic [NS_W-1:0]      r_ns, w_ns_n;
    logic [FRAC_W-1:0]    r_frac, w_frac_n;
    logic                 r_sec_pulse;
    logic [FRAC_W:0]      w_frac_sum;
    logic [NS_W+1:0]      w_ns_inc;
    logic [NS_W-1:0]      w_adj_mag;
    logic signed [NS_W+2:0] w_ns_adj;
    logic                 w_roll;
    logic                 w_disc;

    // Out-of-range ns values saturate to the last ns of the second.
    function automatic logic [NS_W-1:0] ns_sat(input logic [NS_W-1:0] v);
        return (v >= NS_PER_SEC) ? NS_MAX : v;
    endfunction

    // Next time value, in priority clear > load > adjust > increment
    always_comb begin
        w_frac_sum = {1'b0, r_frac} + {1'b0, tick_inc_i[FRAC_W-1:0]};
        w_ns_inc   = {2'b00, r_ns} + (NS_W+2)'(tick_inc_i[31:FRAC_W])
                   + (NS_W+2)'(w_frac_sum[FRAC_W]);
        w_adj_mag  = ns_sat(adj_ns_i);
        w_ns_adj   = $signed({1'b0, w_ns_inc})
                   + (adj_neg_i ? -$signed({3'b000, w_adj_mag})
                                :  $signed({3'b000, w_adj_mag}));
        w_sec_n    = r_sec;
        w_ns_n     = r_ns;
        w_frac_n   = r_frac;
        w_roll     = 1'b0;
        w_disc     = 1'b0;

        if (clr_i) begin
            w_sec_n  = '0;
            w_ns_n   = '0;
            w_frac_n = '0;
            w_disc   = 1'b1;
        end else if (ofst_ld_i) begin
            w_sec_n  = sc_ofst_i;
            w_ns_n   = ns_sat(ns_ofst_i);
            w_frac_n = '0;
            w_disc   = 1'b1;
        end else if (adj_i) begin
            w_frac_n = w_frac_sum[FRAC_W-1:0];
            w_disc   = 1'b1;
            // Result is known to lie within one second of range, so the
            // low 30 bits modulo 2^30 give the corrected ns directly.
            if (w_ns_adj < 0) begin
                w_ns_n  = w_ns_adj[NS_W-1:0] + NS_PER_SEC;
                w_sec_n = r_sec - SEC_W'(1);
            end else if (w_ns_adj >= $signed({3'b000, NS_PER_SEC})) begin
                w_ns_n  = w_ns_adj[NS_W-1:0] - NS_PER_SEC;
                w_sec_n = r_sec + SEC_W'(1);
            end else begin
                w_ns_n  = w_ns_adj[NS_W-1:0];
            end
        end else begin
            w_frac_n = w_frac_sum[FRAC_W-1:0];
            if (w_ns_inc >= {2'b00, NS_PER_SEC}) begin
                w_ns_n  = w_ns_inc[NS_W-1:0] - NS_PER_SEC;
                w_sec_n = r_sec + SEC_W'(1);
                w_roll  = 1'b1;
            end else begin
                w_ns_n  = w_ns_inc[NS_W-1:0];
            end
        end
    end

    // Time registers and the natural-rollover strobe
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            r_sec       <= '0;
            r_ns        <= '0;
            r_frac      <= '0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_sec       <= w_sec_n;
            r_ns        <= w_ns_n;
            r_frac      <= w_frac_n;
            r_sec_pulse <= w_roll;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        rtc_pulse_ch #(
            .PW_W (PW_W)
        ) u_ch (
            .i_clk      (rtc_clk),
            .i_rst      (rtc_rst),
            .i_en       (ch_en_i[g]),
            .i_period   (ch_period_i[g*NS_W +: NS_W]),
            .i_width    (ch_width_i[g*PW_W +: PW_W]),
            .i_ns_n     (w_ns_n),
            .i_rollover (w_roll),
            .i_discont  (w_disc),
            .o_pulse    (pulse_o[g])
        );
    end

    assign rtc_std_o   = {r_sec, 2'b00, r_ns};
    assign sec_pulse_o = r_sec_pulse;

endmodule
